// File: rtl/rr_stream_mux_pkg.sv
// Shared constants and the round-robin search used by the 4:1 stream mux
// and by its companion demux.
package rr_mux_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  // Returns {hit, grant}: the first asserted request in the order
  // last+1, last+2, last+3, last+4 (mod NUM_CH). hit=0 when req is empty.
  function automatic logic [SEL_W:0] next_rr(input logic [NUM_CH-1:0] req,
                                             input logic [SEL_W-1:0]  last);
    logic             hit;
    logic [SEL_W-1:0] grant;
    logic [SEL_W-1:0] idx;
    hit   = 1'b0;
    grant = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      // The SEL_W-bit sum wraps modulo NUM_CH for free.
      idx = last + SEL_W'(i);
      if (!hit && req[idx]) begin
        hit   = 1'b1;
        grant = idx;
      end
    end
    return {hit, grant};
  endfunction

endpackage

// File: rtl/rr_stream_mux_if.sv
// Bundle of the four input streams and the merged output stream.
// slave  = the mux itself; master = the producers/consumer around it.
interface rr_stream_mux_if
  import rr_mux_pkg::*;
#(
  parameter int WIDTH = 8
) ();

  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_ready;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

endinterface

// File: rtl/rr_stream_mux_arb.sv
// Combinational 4-way round-robin arbiter. Holds no state: the caller owns
// the last-grant register, so this block can be shared with the demux side.
module rr_arbiter4
  import rr_mux_pkg::*;
(
  input  logic [NUM_CH-1:0] i_req,
  input  logic [SEL_W-1:0]  i_last,
  output logic              o_hit,
  output logic [SEL_W-1:0]  o_grant,
  output logic [NUM_CH-1:0] o_onehot
);

  logic [SEL_W:0] w_result;

  assign w_result = next_rr(i_req, i_last);
  assign o_hit    = w_result[SEL_W];
  assign o_grant  = w_result[SEL_W-1:0];

  // Expand the winning index into a one-hot vector, empty when nothing won.
  always_comb begin
    o_onehot = '0;
    if (o_hit) o_onehot[o_grant] = 1'b1;
  end

endmodule

// File: rtl/rr_stream_mux.sv
// 4:1 round-robin stream merger with a single registered output stage.
// Each output beat carries the index of the channel it came from.
module rr_stream_mux
  import rr_mux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  rr_stream_mux_if.slave  bus
);

  logic              r_out_valid;
  logic [WIDTH-1:0]  r_out_data;
  logic [SEL_W-1:0]  r_out_sel;
  logic [SEL_W-1:0]  r_last_grant;

  logic              w_hit;
  logic [SEL_W-1:0]  w_grant;
  logic [NUM_CH-1:0] w_onehot;
  logic              w_can_load;
  logic              w_take;

  rr_arbiter4 u_arb (
    .i_req    (bus.in_valid),
    .i_last   (r_last_grant),
    .o_hit    (w_hit),
    .o_grant  (w_grant),
    .o_onehot (w_onehot)
  );

  // The output register may refill in the same cycle it drains.
  assign w_can_load = !r_out_valid || bus.out_ready;
  // in_ready is held low during reset even though the state is already cleared.
  assign w_take     = w_hit && w_can_load && !rst;

  // Accept strobe goes only to the granted channel, and only when we can load.
  always_comb begin
    // NOTE: default first so every path assigns in_ready and no latch is inferred.
    bus.in_ready = '0;
    if (w_take) bus.in_ready = w_onehot;
  end

  // Output register and last-grant pointer; priority starts at channel 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_sel    <= '0;
      r_last_grant <= SEL_W'(NUM_CH - 1);
    end else if (w_take) begin
      // NOTE: non-blocking so every register samples pre-edge values.
      r_out_valid  <= 1'b1;
      r_out_data   <= bus.in_data[w_grant*WIDTH +: WIDTH];
      r_out_sel    <= w_grant;
      r_last_grant <= w_grant;
    end else if (bus.out_ready) begin
      // Drained with nothing new: data/sel keep their last values.
      r_out_valid  <= 1'b0;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_sel   = r_out_sel;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Scoreboard bench for rr_stream_mux: directed scenarios followed by random traffic.
module tb_rr_stream_mux;

  localparam int W = 8;

  logic clk;
  logic rst;

  rr_stream_mux_if #(.WIDTH(W)) bus ();

  rr_stream_mux #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [1:0]   sel;
    logic [W-1:0] data;
  } beat_t;

  beat_t        sb[$];
  int           n_checks = 0;
  int           n_errors = 0;

  // Reference state: is a beat waiting on the output, and who won last.
  bit           m_full;
  int           m_last;

  logic [3:0]   cur_v;
  logic [W-1:0] cur_d[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus. Inputs change on the falling edge; at +2 the
  // expected handshake is computed from the round-robin rule and any accepted
  // beat is queued for the monitor.
  task automatic step(input logic rst_v, input logic ordy);
    int  g;
    bit  hit;
    bit  can_load;
    logic [3:0] exp_rdy;
    @(negedge clk);
    rst           = rst_v;
    bus.in_valid  = cur_v;
    bus.in_data   = {cur_d[3], cur_d[2], cur_d[1], cur_d[0]};
    bus.out_ready = ordy;
    if (rst_v) begin
      sb.delete();
      m_full = 1'b0;
      m_last = 3;
    end
    #2;
    hit = 1'b0;
    g   = 0;
    for (int i = 1; i <= 4; i++) begin
      if (!hit && cur_v[(m_last + i) % 4]) begin
        hit = 1'b1;
        g   = (m_last + i) % 4;
      end
    end
    can_load = !m_full || ordy;
    exp_rdy  = '0;
    if (rst_v) begin
      check("rst_out_sel",  32'(bus.out_sel),  32'd0);
      check("rst_out_data", 32'(bus.out_data), 32'd0);
    end else if (hit && can_load) begin
      exp_rdy[g] = 1'b1;
    end
    check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    if (!rst_v) begin
      if (exp_rdy != 0) begin
        sb.push_back('{sel: 2'(g), data: cur_d[g]});
        m_last   = g;
        m_full   = 1'b1;
        cur_v[g] = 1'b0;
      end else if (ordy) begin
        m_full = 1'b0;
      end
    end
  endtask

  // Monitor: the output must show exactly the oldest queued beat, held
  // stable until it is taken.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      check("out_valid", 32'(bus.out_valid), 32'(sb.size() != 0));
      if (bus.out_valid && sb.size() != 0) begin
        check("out_sel",  32'(bus.out_sel),  32'(sb[0].sel));
        check("out_data", 32'(bus.out_data), 32'(sb[0].data));
        if (bus.out_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    m_full        = 1'b0;
    m_last        = 3;

    // Reset with every channel requesting, then eight cycles of full load.
    for (int k = 0; k < 4; k++) cur_d[k] = W'(8'h10 + k);
    cur_v = 4'hF;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cur_v = 4'hF;
      step(1'b0, 1'b1);
    end
    cur_v = 4'h0;
    step(1'b0, 1'b1);

    // Lone request on channel 2.
    cur_v    = 4'b0100;
    cur_d[2] = 8'hA5;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);

    // Backpressure holding a channel-1 beat while channels 0 and 2 wait.
    cur_v    = 4'b0010;
    cur_d[1] = 8'h3C;
    step(1'b0, 1'b1);
    cur_v    = 4'b0101;
    cur_d[0] = 8'h11;
    cur_d[2] = 8'h22;
    repeat (5) step(1'b0, 1'b0);
    step(1'b0, 1'b1);

    // Drain and refill in one cycle from channel 3, then channel 0 goes.
    cur_v[3] = 1'b1;
    cur_d[3] = 8'h5A;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    cur_v = 4'h0;
    step(1'b0, 1'b1);

    // Reset while a beat is stalled; channel 0 must win afterwards.
    cur_v    = 4'b0010;
    cur_d[1] = 8'h77;
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    cur_v = 4'hF;
    for (int k = 0; k < 4; k++) cur_d[k] = W'(8'hC0 + k);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);

    // Random traffic; a channel only changes its beat after being accepted.
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 4; k++) begin
        if (!cur_v[k] && $urandom_range(0, 2) != 0) begin
          cur_v[k] = 1'b1;
          cur_d[k] = W'($urandom);
        end
      end
      step(1'b0, $urandom_range(0, 3) != 0);
    end

    // Bounded final drain.
    cur_v = 4'h0;
    for (int n = 0; n < 10 && sb.size() != 0; n++) step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("final_drain", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
